// File: rtl/img_accel_pkg.sv
// Shared types and default widths for the image accelerator write path.
package img_accel_pkg;

   localparam int unsigned PIX_W_DEF        = 12;
   localparam int unsigned PIX_PER_WORD_DEF = 9;
   localparam int unsigned DATA_SIZE_DEF    = 108;
   localparam int unsigned ADD_SIZE_DEF     = 12;

   typedef enum logic [1:0] {
      FILL,
      ISSUE,
      WAIT_ACK
   } packer_state_t;

endpackage

// File: rtl/pixel_word_packer.sv
// Packs PIX_PER_WORD pixels into one word and writes it to the memory controller with retry on ack timeout.
// Optional build macro PACKER_WORD_CNT_EN adds the saturating words_written output.
module pixel_word_packer
   import img_accel_pkg::*;
#(
   parameter int unsigned PIX_W        = PIX_W_DEF,
   parameter int unsigned PIX_PER_WORD = PIX_PER_WORD_DEF,
   parameter int unsigned DATA_SIZE    = DATA_SIZE_DEF,
   parameter int unsigned ADD_SIZE     = ADD_SIZE_DEF,
   parameter int unsigned ACK_TIMEOUT  = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic [PIX_W-1:0]     pix_data,
   input  logic                 pix_last,
   output logic                 in_valid,
   output logic                 write_en,
   output logic [ADD_SIZE-1:0]  address_out,
   output logic [DATA_SIZE-1:0] data_out,
   input  logic                 out_ready,
   output logic                 frame_done,
   output logic                 err_timeout
`ifdef PACKER_WORD_CNT_EN
   ,
   output logic [ADD_SIZE:0]    words_written
`endif
);

   localparam int unsigned LANE_W = $clog2(PIX_PER_WORD + 1);
   localparam int unsigned TO_W   = $clog2(ACK_TIMEOUT + 1);

   packer_state_t        state_q, state_d;
   logic [LANE_W-1:0]    lane_q, lane_d;
   logic [TO_W-1:0]      cnt_q, cnt_d;
   logic                 last_q, last_d;
   logic [DATA_SIZE-1:0] word_d;
   logic [ADD_SIZE-1:0]  addr_d;
   logic                 ready_d, valid_d, done_d, err_d;
   logic                 ack;

   assign ack = (state_q == WAIT_ACK) && out_ready;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= FILL;
      else      state_q <= state_d;
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      word_d  = data_out;
      addr_d  = address_out;
      err_d   = err_timeout;
      done_d  = 1'b0;

      case (state_q)
         FILL: begin
            if (pix_valid && pix_ready) begin
               for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
                  if (lane_q == LANE_W'(i)) word_d[i*PIX_W +: PIX_W] = pix_data;
               end
               lane_d = lane_q + LANE_W'(1);
               last_d = pix_last;
               if (lane_q == LANE_W'(PIX_PER_WORD - 1) || pix_last) state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (out_ready) begin
               state_d = FILL;
               word_d  = '0;
               lane_d  = '0;
               last_d  = 1'b0;
               if (last_q) begin
                  done_d = 1'b1;
                  addr_d = '0;
               end else begin
                  addr_d = address_out + ADD_SIZE'(1);
               end
            end else if (cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
               // Re-issue the same word and address after a missing acknowledge
               err_d   = 1'b1;
               state_d = ISSUE;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         default: state_d = FILL;
      endcase

      ready_d = (state_d == FILL);
      // Request rises one cycle after entering ISSUE and holds through retries
      valid_d = (state_q == ISSUE) || ((state_q == WAIT_ACK) && !out_ready);
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_q      <= '0;
         cnt_q       <= '0;
         last_q      <= 1'b0;
         data_out    <= '0;
         address_out <= '0;
         pix_ready   <= 1'b0;
         in_valid    <= 1'b0;
         write_en    <= 1'b0;
         frame_done  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         lane_q      <= lane_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         data_out    <= word_d;
         address_out <= addr_d;
         pix_ready   <= ready_d;
         in_valid    <= valid_d;
         write_en    <= valid_d;
         frame_done  <= done_d;
         err_timeout <= err_d;
      end
   end

`ifdef PACKER_WORD_CNT_EN
   // Lifetime count of acknowledged words, saturating
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             words_written <= '0;
      else if (ack && (words_written != '1)) words_written <= words_written + (ADD_SIZE+1)'(1);
   end
`else
   logic unused_ack;
   assign unused_ack = ack;
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed self-checking bench for pixel_word_packer.
module tb_pixel_word_packer;

   logic          clk = 1'b0;
   logic          rst;
   logic          pix_valid;
   logic          pix_ready;
   logic [11:0]   pix_data;
   logic          pix_last;
   logic          in_valid;
   logic          write_en;
   logic [11:0]   address_out;
   logic [107:0]  data_out;
   logic          out_ready;
   logic          frame_done;
   logic          err_timeout;
`ifdef PACKER_WORD_CNT_EN
   logic [12:0]   words_written;
`endif

   int vectors = 0;
   int errors  = 0;

   pixel_word_packer dut (
      .clk         (clk),
      .rst         (rst),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_data    (pix_data),
      .pix_last    (pix_last),
      .in_valid    (in_valid),
      .write_en    (write_en),
      .address_out (address_out),
      .data_out    (data_out),
      .out_ready   (out_ready),
      .frame_done  (frame_done),
      .err_timeout (err_timeout)
`ifdef PACKER_WORD_CNT_EN
      ,
      .words_written (words_written)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [11:0] d, input logic last);
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = last;
      step();
   endtask

   initial begin
      rst = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0; out_ready = 1'b0;
      step(); step(); step();
      check("rst_pix_ready", 128'(pix_ready), 128'(0));
      check("rst_in_valid", 128'(in_valid), 128'(0));
      check("rst_write_en", 128'(write_en), 128'(0));
      check("rst_addr", 128'(address_out), 128'(0));
      check("rst_data", 128'(data_out), 128'(0));
      check("rst_done", 128'(frame_done), 128'(0));
      check("rst_err", 128'(err_timeout), 128'(0));
      rst = 1'b1;
      step();
      check("ready_after_rst", 128'(pix_ready), 128'(1));

      // Full word 0x001..0x009, ack 4 cycles after issue
      for (int i = 1; i <= 9; i++) push(12'(i), 1'b0);
      pix_valid = 1'b0;
      check("w1_ready_drop", 128'(pix_ready), 128'(0));
      check("w1_valid_lag", 128'(in_valid), 128'(0));
      step();
      check("w1_valid", 128'(in_valid), 128'(1));
      check("w1_wen", 128'(write_en), 128'(1));
      check("w1_data", 128'(data_out), 128'(108'h009008007006005004003002001));
      check("w1_addr", 128'(address_out), 128'(0));
      step(); step(); step();
      check("w1_hold", 128'(in_valid), 128'(1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("w1_ack_valid", 128'(in_valid), 128'(0));
      check("w1_ack_addr", 128'(address_out), 128'(1));
      check("w1_ack_ready", 128'(pix_ready), 128'(1));
      check("w1_ack_cleared", 128'(data_out), 128'(0));
      check("w1_no_done", 128'(frame_done), 128'(0));

      // Partial word ended by pix_last
      for (int i = 0; i < 4; i++) push(12'hAAA, i == 3);
      pix_valid = 1'b0; pix_last = 1'b0;
      step();
      check("w2_valid", 128'(in_valid), 128'(1));
      check("w2_data", 128'(data_out), 128'(108'hAAAAAAAAAAAA));
      check("w2_addr", 128'(address_out), 128'(1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("w2_done", 128'(frame_done), 128'(1));
      check("w2_addr_reset", 128'(address_out), 128'(0));
      step();
      check("w2_done_pulse", 128'(frame_done), 128'(0));

      // Held pix_valid across issue/wait is not consumed
      for (int i = 1; i <= 9; i++) push(12'h100 + 12'(i), 1'b0);
      pix_data = 12'h1FF;
      step();
      check("w3_data", 128'(data_out), 128'(108'h109108107106105104103102101));
      step(); step();
      check("w3_ready_low", 128'(pix_ready), 128'(0));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      for (int i = 2; i <= 9; i++) push(12'h200 + 12'(i), 1'b0);
      pix_valid = 1'b0;
      step();
      check("w4_data", 128'(data_out), 128'(108'h2092082072062052042032021FF));
      check("w4_addr", 128'(address_out), 128'(1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("w4_ack_addr", 128'(address_out), 128'(2));

      // Ack timeout and retry
      for (int i = 1; i <= 9; i++) push(12'h300 + 12'(i), 1'b0);
      pix_valid = 1'b0;
      step();
      check("to_valid", 128'(in_valid), 128'(1));
      for (int i = 0; i < 14; i++) step();
      check("to_err_early", 128'(err_timeout), 128'(0));
      step();
      check("to_err", 128'(err_timeout), 128'(1));
      check("to_valid_hold", 128'(in_valid), 128'(1));
      check("to_data_hold", 128'(data_out), 128'(108'h309308307306305304303302301));
      check("to_addr_hold", 128'(address_out), 128'(2));
      out_ready = 1'b1;
      step();
      check("to_issue_ignores_ack", 128'(in_valid), 128'(1));
      step();
      out_ready = 1'b0;
      check("to_ack_valid", 128'(in_valid), 128'(0));
      check("to_ack_addr", 128'(address_out), 128'(3));
      check("to_err_sticky", 128'(err_timeout), 128'(1));

      // Reset during WAIT_ACK
      for (int i = 1; i <= 9; i++) push(12'h400 + 12'(i), 1'b0);
      pix_valid = 1'b0;
      step(); step();
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 128'(in_valid), 128'(0));
      check("arst_data", 128'(data_out), 128'(0));
      check("arst_err", 128'(err_timeout), 128'(0));
      check("arst_addr", 128'(address_out), 128'(0));
      step();
      check("arst_ready", 128'(pix_ready), 128'(0));
      rst = 1'b1;
      step();
      // Ninth pixel with pix_last is one full word
      for (int i = 1; i <= 9; i++) push(12'h500 + 12'(i), i == 9);
      pix_valid = 1'b0; pix_last = 1'b0;
      step();
      check("post_rst_data", 128'(data_out), 128'(108'h509508507506505504503502501));
      check("post_rst_addr", 128'(address_out), 128'(0));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("last9_done", 128'(frame_done), 128'(1));
      check("last9_addr", 128'(address_out), 128'(0));
      step();
      check("last9_single", 128'(in_valid), 128'(0));

      // Address wrap after 4095 acknowledged words
      pix_valid = 1'b1; pix_last = 1'b0; pix_data = 12'h055; out_ready = 1'b1;
      for (int w = 0; w < 4095; w++) begin
         for (int i = 0; i < 11; i++) step();
      end
      for (int i = 0; i < 10; i++) step();
      check("wrap_issue_addr", 128'(address_out), 128'(4095));
      check("wrap_issue_valid", 128'(in_valid), 128'(1));
      step();
      check("wrap_addr_zero", 128'(address_out), 128'(0));
      for (int i = 0; i < 10; i++) step();
      check("wrap_next_issue", 128'(address_out), 128'(0));
      check("wrap_next_valid", 128'(in_valid), 128'(1));
      out_ready = 1'b0; pix_valid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Upstream neighbour of the write memory controller. It accepts a stream of 12-bit pixels over a valid/ready handshake and packs nine consecutive pixels into one 108-bit word. It then presents the word with a sequential address to the controller's `in_valid`/`write_en`/`address_in`/`dataIn` inputs. It holds the word until the controller's `out_ready` acknowledge, and recovers by re-issuing if no acknowledge arrives.

## Interface
Parameters:
- `PIX_W`, 12, pixel width in bits
- `PIX_PER_WORD`, 9, pixels per packed word
- `DATA_SIZE`, 108, word width; must equal `PIX_W*PIX_PER_WORD`
- `ADD_SIZE`, 12, address width
- `ACK_TIMEOUT`, 15, maximum WAIT_ACK cycles before re-issue

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `pix_valid`  in  1  upstream pixel valid
- `pix_ready`  out  1  packer can accept a pixel
- `pix_data`  in  `PIX_W`  pixel value
- `pix_last`  in  1  qualifies the final pixel of a frame
- `in_valid`  out  1  word pending, to controller `in_valid`
- `write_en`  out  1  to controller `write_en`
- `address_out`  out  `ADD_SIZE`  word address, to controller `address_in`
- `data_out`  out  `DATA_SIZE`  packed word, to controller `dataIn`
- `out_ready`  in  1  controller acknowledge pulse
- `frame_done`  out  1  one-cycle pulse when the last word of a frame is acknowledged
- `err_timeout`  out  1  sticky; set on any ack timeout, cleared only by reset

## Operation
- States: FILL, ISSUE, WAIT_ACK. The reset state is FILL.
- **FILL**
  - `pix_ready`=1.
  - Each accepted pixel (`pix_valid && pix_ready`) is written to lane `lane_cnt` of the word, at bits [`lane_cnt*PIX_W +: PIX_W`]. The first pixel goes to the LSBs.
  - `lane_cnt` then increments.
  - When the accepted pixel is in lane `PIX_PER_WORD-1`, or `pix_last`=1, go to ISSUE. `last_flag` latches `pix_last`.
- **Partial word on `pix_last`:** unfilled upper lanes are zero. The word register is cleared on every acknowledge.
- **ISSUE**
  - `pix_ready`=0.
  - `in_valid`=1, `write_en`=1; `data_out` and `address_out` are stable.
  - Go to WAIT_ACK next cycle. The timeout counter loads 0.
- **WAIT_ACK**
  - Outputs are held exactly as in ISSUE. The counter increments each cycle.
  - If `out_ready`=1: deassert `in_valid`/`write_en`, clear the word and `lane_cnt`, and go to FILL.
    - If `last_flag` is set: pulse `frame_done` and reset the address to 0.
    - Otherwise: address+1, wrapping from 2^`ADD_SIZE`-1 to 0.
  - If the counter reaches `ACK_TIMEOUT` without `out_ready`: set `err_timeout` and return to ISSUE with the same word and address (retry).
- `out_ready` seen in FILL or ISSUE is ignored.
- `pix_valid` while `pix_ready`=0 is not consumed; upstream must hold it.

## Timing
- Reset values: `pix_ready`=0, `in_valid`=0, `write_en`=0, `address_out`=0, `data_out`=0, `frame_done`=0, `err_timeout`=0, `lane_cnt`=0. All outputs are registered.
- `pix_ready` rises on the first rising edge after `rst` deasserts.
- The pixel completing a word is accepted on edge N. `in_valid`/`write_en` go high after edge N+1 (entry to ISSUE), and `pix_ready` drops after edge N.
- `out_ready` sampled high on edge M causes the following after edge M: `in_valid`=0, the new address, `pix_ready`=1, and a `frame_done` pulse if applicable.
- Minimum cost per word with a 4-cycle controller turnaround: 9 fill cycles + 1 ISSUE + ack wait.
- `pix_last` together with a ninth-lane pixel is a single full word, not two.
- Reset asserted mid-operation immediately forces the reset values. The partial word and any pending write are discarded.

## Configuration
- `PACKER_WORD_CNT_EN`
  - Defined: adds output `words_written` [`ADD_SIZE`:0]. It resets to 0, increments on each acknowledge, and saturates at all-ones. It is not cleared by frame end.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `img_accel_pkg`:
  - State enum `packer_state_t` (FILL, ISSUE, WAIT_ACK).
  - Constants `PIX_W_DEF`=12, `PIX_PER_WORD_DEF`=9, `DATA_SIZE_DEF`=108, `ADD_SIZE_DEF`=12.
- No sub-module is required. The lane register and counter stay inline in `pixel_word_packer`.

## Test plan
- Pixels 0x001..0x009, `out_ready` 4 cycles after ISSUE -> `data_out`=0x009_008_..._001 at address 0. After the ack, address=1 and `pix_ready`=1.
- 4 pixels 0xAAA with `pix_last` on the fourth -> lanes 0-3=0xAAA and lanes 4-8=0. After the ack: `frame_done` pulses once and address returns to 0.
- `pix_valid` held high throughout ISSUE/WAIT_ACK -> no pixel accepted while `pix_ready`=0. The next word starts with the held pixel, so none are lost or duplicated.
- Preload 4095 words acknowledged -> the 4096th word issues at 4095 and the next at 0.
- `out_ready` never asserted -> `err_timeout`=1 after 15 WAIT_ACK cycles. ISSUE is re-entered with an identical word and address, and a later ack completes normally.
- `rst` pulled low during WAIT_ACK -> all outputs are at reset values while low. The partial word is gone, and the first word after release goes to address 0.
